// File: rtl/rv32i_types.sv
// RV32I encoding constants shared by the front-end blocks.
package rv32i_types;

    localparam logic [6:0] op_jal  = 7'b1101111;
    localparam logic [6:0] op_jalr = 7'b1100111;
    localparam logic [6:0] op_br   = 7'b1100011;

    localparam int unsigned xlen = 32;

endpackage : rv32i_types

// File: rtl/fetch_queue_predecode.sv
// Combinational predecode: flags control-flow instructions (JAL, JALR, BRANCH).
module fetch_queue_predecode
    import rv32i_types::*;
(
    input  logic [31:0] instr,
    output logic        is_ctrl
);

    // Only the opcode field decides control flow; the rest is deliberately ignored.
    logic unused_fields_s;
    assign unused_fields_s = ^instr[31:7];

    // Opcode match against the three control-flow major opcodes.
    always_comb begin
        is_ctrl = 1'b0;
        case (instr[6:0])
            op_jal, op_jalr, op_br: is_ctrl = 1'b1;
            default:                is_ctrl = 1'b0;
        endcase
    end

endmodule : fetch_queue_predecode

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular queue of
// instruction/PC pairs with a predecoded control-flow flag, one-cycle flush.
module fetch_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        enq_valid,
    output logic        enq_ready,
    input  logic [31:0] enq_instr,
    input  logic [31:0] enq_pc,
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [31:0] deq_instr,
    output logic [31:0] deq_pc,
    output logic        deq_is_ctrl
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] full_count_c = CW'(DEPTH);

    logic [31:0]   instr_r   [DEPTH];
    logic [31:0]   pc_r      [DEPTH];
    logic          is_ctrl_r [DEPTH];
    logic [PW-1:0] head_ptr_r;
    logic [PW-1:0] tail_ptr_r;
    logic [CW-1:0] count_r;

    logic enq_fire_s;
    logic deq_fire_s;
    logic enq_is_ctrl_s;

    fetch_queue_predecode u_predecode (
        .instr   (enq_instr),
        .is_ctrl (enq_is_ctrl_s)
    );

    // Handshake outputs: flush masks both sides so nothing moves during a redirect.
    always_comb begin
        enq_ready  = (count_r != full_count_c) & ~flush;
        deq_valid  = (count_r != CW'(0)) & ~flush;
        enq_fire_s = enq_valid & enq_ready;
        deq_fire_s = deq_valid & deq_ready;
    end

    // Head entry is presented straight from storage; meaningless while deq_valid is low.
    always_comb begin
        deq_instr   = instr_r[head_ptr_r];
        deq_pc      = pc_r[head_ptr_r];
        deq_is_ctrl = is_ctrl_r[head_ptr_r];
    end

    // Entry storage: written at the tail on enqueue, never cleared.
    always_ff @(posedge clk) begin
        if (enq_fire_s) begin
            instr_r[tail_ptr_r]   <= enq_instr;
            pc_r[tail_ptr_r]      <= enq_pc;
            is_ctrl_r[tail_ptr_r] <= enq_is_ctrl_s;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr_r <= PW'(0);
            tail_ptr_r <= PW'(0);
            count_r    <= CW'(0);
        end else if (flush) begin
            head_ptr_r <= PW'(0);
            tail_ptr_r <= PW'(0);
            count_r    <= CW'(0);
        end else begin
            if (enq_fire_s) begin
                tail_ptr_r <= tail_ptr_r + PW'(1);
            end
            if (deq_fire_s) begin
                head_ptr_r <= head_ptr_r + PW'(1);
            end
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule : fetch_queue
